mem_input_loader: RTL and testbench

Bus initiator that writes one flattened input image into the unified data memory before inference starts. On `start` it captures a WORDS×DATA_WIDTH input vector and issues WORDS consecutive single-word writes to the memory's word port, starting at the input region base (82150). This lets a new image be loaded at run time instead of from the power-on hex image. It sits between the top-level image source and the memory's `addr`/`Memwrite`/`MDin` port, muxed with the CPU side while `busy` is high.

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/loader_word_sel.sv | 20 ++
 rtl/mem_input_loader.sv | 161 ++++++++++++++++
 tb/tb_mem_input_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared memory map and loader types for the CPU data memory.
// The VERIFY state exists only when LOADER_VERIFY_EN is defined.
package cpu_mem_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 17;

  localparam int FC1_W_BASE  = 1024;
  localparam int FC1_B_BASE  = 79424;
  localparam int FC2_W_BASE  = 79524;
  localparam int FC2_B_BASE  = 82124;
  localparam int INPUT_BASE  = 82150;
  localparam int INPUT_WORDS = 784;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef LOADER_VERIFY_EN
    VERIFY = 2'd2,
`endif
    FINISH = 2'd3
  } loader_state_t;

endpackage

// File: rtl/loader_word_sel.sv
// Combinational WORDS:1 word mux over the captured image buffer.
module loader_word_sel #(
  parameter int DATA_WIDTH = cpu_mem_pkg::DATA_WIDTH,
  parameter int WORDS      = cpu_mem_pkg::INPUT_WORDS,
  parameter int IDX_W      = $clog2(WORDS)
) (
  input  logic [WORDS*DATA_WIDTH-1:0] image,
  input  logic [IDX_W-1:0]            index,
  output logic [DATA_WIDTH-1:0]       word
);

  // Indices past the last word (possible when WORDS is not a power of two) read as zero.
  always_comb begin
    word = '0;
    if (int'(index) < WORDS) begin
      word = image[int'(index)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/mem_input_loader.sv
// Writes one WORDS-word input image into the data memory after a start pulse.
// Define LOADER_VERIFY_EN to add a read-back pass reporting err/err_cnt.
module mem_input_loader #(
  parameter int DATA_WIDTH = cpu_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_mem_pkg::ADDR_WIDTH,
  parameter int WORDS      = cpu_mem_pkg::INPUT_WORDS,
  parameter int BASE_ADDR  = cpu_mem_pkg::INPUT_BASE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WORDS*DATA_WIDTH-1:0]   InputData,
  input  logic [DATA_WIDTH-1:0]         data,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic                          Memwrite,
  output logic [DATA_WIDTH-1:0]         MDin,
  output logic                          busy,
`ifdef LOADER_VERIFY_EN
  output logic                          err,
  output logic [$clog2(WORDS+1)-1:0]    err_cnt,
`endif
  output logic                          done
);

  import cpu_mem_pkg::*;

  localparam int                    IDX_W    = $clog2(WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t               state;
  logic [WORDS*DATA_WIDTH-1:0] image_buf;
  logic [IDX_W-1:0]            idx;
  logic [IDX_W-1:0]            sel_idx;
  logic [DATA_WIDTH-1:0]       sel_word;
  logic                        armed;
  logic                        accept;

  // armed stays low for the first edge after reset so a start overlapping release is dropped.
  assign accept = (state == IDLE) && start && armed;

`ifdef LOADER_VERIFY_EN
  localparam int               CNT_W   = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WORDS);

  logic [IDX_W-1:0] cmp_idx;
  logic             cmp_valid;
  logic             issue_done;

  assign sel_idx = (state == VERIFY) ? cmp_idx : idx;
`else
  logic unused_data;

  assign unused_data = ^data;
  assign sel_idx     = idx;
`endif

  loader_word_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (WORDS),
    .IDX_W      (IDX_W)
  ) u_word_sel (
    .image (image_buf),
    .index (sel_idx),
    .word  (sel_word)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      image_buf <= InputData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      armed      <= 1'b0;
      addr       <= '0;
      MDin       <= '0;
      Memwrite   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef LOADER_VERIFY_EN
      cmp_idx    <= '0;
      cmp_valid  <= 1'b0;
      issue_done <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
`endif
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
`ifdef LOADER_VERIFY_EN
            err     <= 1'b0;
            err_cnt <= '0;
`endif
          end
        end

        LOAD: begin
          addr     <= BASE + ADDR_WIDTH'(idx);
          MDin     <= sel_word;
          Memwrite <= 1'b1;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx <= '0;
`ifdef LOADER_VERIFY_EN
            cmp_valid  <= 1'b0;
            issue_done <= 1'b0;
            state      <= VERIFY;
`else
            state      <= FINISH;
`endif
          end
        end

`ifdef LOADER_VERIFY_EN
        // Read data for the address issued last cycle arrives now, so compares trail by one.
        VERIFY: begin
          Memwrite <= 1'b0;
          if (cmp_valid && (data != sel_word)) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
          if (!issue_done) begin
            addr      <= BASE + ADDR_WIDTH'(idx);
            cmp_idx   <= idx;
            cmp_valid <= 1'b1;
            idx       <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              issue_done <= 1'b1;
            end
          end else begin
            cmp_valid <= 1'b0;
            state     <= FINISH;
          end
        end
`endif

        FINISH: begin
          Memwrite <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_input_loader.sv
// Scoreboard bench for mem_input_loader with a negedge-sampled word memory model.
// Covers the LOADER_VERIFY_EN build as well when that macro is defined.
module tb_mem_input_loader;

  localparam int DW    = 32;
  localparam int AW    = 17;
  localparam int WORDS = 784;
  localparam int BASE  = 82150;
`ifdef LOADER_VERIFY_EN
  localparam int DONE_LAT = 2*WORDS + 2;
`else
  localparam int DONE_LAT = WORDS + 1;
`endif

  logic                clk;
  logic                rst;
  logic                start;
  logic [WORDS*DW-1:0] InputData;
  logic [DW-1:0]       data;
  logic [AW-1:0]       addr;
  logic                Memwrite;
  logic [DW-1:0]       MDin;
  logic                busy;
  logic                done;
`ifdef LOADER_VERIFY_EN
  logic                err;
  logic [$clog2(WORDS+1)-1:0] err_cnt;
`endif

  mem_input_loader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .WORDS      (WORDS),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .InputData (InputData),
    .data      (data),
    .addr      (addr),
    .Memwrite  (Memwrite),
    .MDin      (MDin),
    .busy      (busy),
`ifdef LOADER_VERIFY_EN
    .err       (err),
    .err_cnt   (err_cnt),
`endif
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tStart = 0;
  int run = 0;
  int lastRun = 0;
  int firstWriteCyc = 0;
  int writeCount = 0;
  int unexpectedWrites = 0;
  int doneCount = 0;
  int doneCyc = 0;
  bit corrupt = 1'b0;
  logic [48:0] sbq[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Memory samples writes and returns read data on the falling edge.
  always @(negedge clk) begin
    if (Memwrite) ram[addr] <= MDin;
    data <= ram[addr] ^ ((corrupt && (addr == AW'(82200) || addr == AW'(82933))) ? 32'h1 : 32'h0);
  end

  always @(negedge clk) begin
    logic [48:0] exp;
    if (Memwrite) begin
      if (run == 0) firstWriteCyc = cyc;
      run++;
      writeCount++;
      if (sbq.size() > 0) begin
        exp = sbq.pop_front();
        checkOutput("wr_addr", 64'(addr), 64'(exp[48:32]));
        checkOutput("wr_data", 64'(MDin), 64'(exp[31:0]));
      end else begin
        unexpectedWrites++;
      end
    end else if (run != 0) begin
      lastRun = run;
      run = 0;
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end
  end

  task automatic buildImage(input logic [DW-1:0] baseVal, input bit incr);
    for (int i = 0; i < WORDS; i++)
      InputData[i*DW +: DW] = incr ? baseVal + DW'(i) : baseVal;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < WORDS; i++)
      sbq.push_back({AW'(BASE + i), InputData[i*DW +: DW]});
    @(posedge clk);
    #1 start = 1'b0;
    tStart = cyc;
  endtask

  task automatic waitDone(input int budget);
    bit seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (seen) begin
      checkOutput("done_latency", 64'(doneCyc - tStart), 64'(DONE_LAT));
      checkOutput("busy_at_done", 64'(busy), 64'd0);
    end else begin
      checkOutput("done_timeout", 64'(done), 64'd1);
    end
  endtask

  task automatic checkImage(input string tag, input logic [DW-1:0] baseVal, input bit incr);
    int ok = 0;
    for (int i = 0; i < WORDS; i++)
      if (ram[BASE + i] === (incr ? baseVal + DW'(i) : baseVal)) ok++;
    checkOutput(tag, 64'(ok), 64'(WORDS));
  endtask

  initial begin
    int d0;
    int w0;
    int guard;
    for (int i = 0; i < (1<<AW); i++) ram[i] = '0;
    rst = 1'b0;
    start = 1'b0;
    data = '0;
    InputData = '0;
    #3;
    checkOutput("rst_addr", 64'(addr), 64'd0);
    checkOutput("rst_mdin", 64'(MDin), 64'd0);
    checkOutput("rst_memwrite", 64'(Memwrite), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Load with a second start pulse mid-load that must be ignored.
    buildImage(32'h1000_0000, 1'b1);
    d0 = doneCount;
    applyStimulus();
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    while (cyc < tStart + 100) begin
      @(negedge clk);
      #1;
    end
    buildImage(32'h5555_0000, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(3000);
    checkOutput("first_write_lat", 64'(firstWriteCyc - tStart), 64'd1);
    checkOutput("write_run_len", 64'(lastRun), 64'(WORDS));
    repeat (5) @(negedge clk);
    checkOutput("done_once", 64'(doneCount - d0), 64'd1);
    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);
    checkImage("mem_image_a", 32'h1000_0000, 1'b1);

    // Reset in the middle of a load: outputs clear at once, tail of memory untouched.
    buildImage(32'h2000_0000, 1'b1);
    applyStimulus();
    w0 = writeCount;
    guard = 0;
    while ((writeCount - w0) < 400 && guard < 2000) begin
      @(negedge clk);
      #2;
      guard++;
    end
    checkOutput("writes_before_rst", 64'(writeCount - w0), 64'd400);
    rst = 1'b0;
    #1;
    checkOutput("midrst_memwrite", 64'(Memwrite), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_addr", 64'(addr), 64'd0);
    sbq.delete();
    d0 = doneCount;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("start_at_release", 64'(busy), 64'd0);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("no_done_after_rst", 64'(doneCount - d0), 64'd0);
    checkOutput("mem_last_new", 64'(ram[BASE + 399]), 64'(32'h2000_0000 + 399));
    checkOutput("mem_first_old", 64'(ram[BASE + 400]), 64'(32'h1000_0000 + 400));
    checkOutput("mem_end_old", 64'(ram[BASE + WORDS - 1]), 64'(32'h1000_0000 + WORDS - 1));

    // Back-to-back loads, second image constant.
    buildImage(32'h1000_0000, 1'b1);
    applyStimulus();
    waitDone(3000);
    buildImage(32'hDEAD_BEEF, 1'b0);
    applyStimulus();
    waitDone(3000);
    checkImage("mem_deadbeef", 32'hDEAD_BEEF, 1'b0);
    checkOutput("unexpected_writes", 64'(unexpectedWrites), 64'd0);

`ifdef LOADER_VERIFY_EN
    checkOutput("vfy_err_clean", 64'(err), 64'd0);
    checkOutput("vfy_cnt_clean", 64'(err_cnt), 64'd0);
    corrupt = 1'b1;
    buildImage(32'h3000_0000, 1'b1);
    applyStimulus();
    waitDone(3000);
    checkOutput("vfy_err_bad", 64'(err), 64'd1);
    checkOutput("vfy_cnt_bad", 64'(err_cnt), 64'd2);
    corrupt = 1'b0;
    applyStimulus();
    checkOutput("vfy_err_cleared", 64'(err), 64'd0);
    checkOutput("vfy_cnt_cleared", 64'(err_cnt), 64'd0);
    waitDone(3000);
    checkOutput("vfy_err_final", 64'(err), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
